// File: rtl/alarm_controller_if.sv
// Signal bundle between the time/keyboard logic and the alarm sequencer.
// The slave side is the alarm controller; the master side drives time, keys and ticks.
interface alarm_controller_if;
   logic        sec_tick;
   logic        alarm_en;
   logic        settime;
   logic        snooze_key;
   logic        stop_key;
   logic [23:0] cur_time;
   logic [23:0] alm_time;
   logic [1:0]  state;
   logic        ringing;
   logic        beep;
   logic [2:0]  snooze_left;

   modport master (
      output sec_tick, alarm_en, settime, snooze_key, stop_key, cur_time, alm_time,
      input  state, ringing, beep, snooze_left
   );

   modport slave (
      input  sec_tick, alarm_en, settime, snooze_key, stop_key, cur_time, alm_time,
      output state, ringing, beep, snooze_left
   );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: detects the rising edge of a time match and walks the alarm
// through ringing, snooze and stop, producing registered ring/beep indications.
module alarm_controller #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input logic               clk,
   input logic               reset,
   alarm_controller_if.slave bus
);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } state_t;

   localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
   localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
   localparam logic [2:0] SNOOZE_INIT = 3'(MAX_SNOOZE);

   state_t     state_q, state_n;
   logic [8:0] count_q, count_n;
   logic [2:0] left_q, left_n;
   logic       beep_q, beep_n;
   logic       ringing_q, ringing_n;
   logic       match, match_d, trig;

   // Editing the clock must never fire the alarm, and a held match fires only once.
   assign match = (bus.cur_time == bus.alm_time) && !bus.settime;
   assign trig  = match && !match_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= DISARMED;
         count_q   <= '0;
         left_q    <= SNOOZE_INIT;
         beep_q    <= 1'b0;
         ringing_q <= 1'b0;
         match_d   <= 1'b0;
      end else begin
         state_q   <= state_n;
         count_q   <= count_n;
         left_q    <= left_n;
         beep_q    <= beep_n;
         ringing_q <= ringing_n;
         match_d   <= match;
      end
   end

   always_comb begin
      state_n = state_q;
      count_n = count_q;
      left_n  = left_q;
      beep_n  = beep_q;

      case (state_q)
         DISARMED: begin
            if (bus.alarm_en) begin
               state_n = ARMED;
               count_n = '0;
               left_n  = SNOOZE_INIT;
               beep_n  = 1'b0;
            end
         end
         ARMED: begin
            if (trig) begin
               state_n = RINGING;
               count_n = '0;
               beep_n  = 1'b1;
            end
         end
         RINGING: begin
            if (bus.stop_key) begin
               state_n = ARMED;
               count_n = '0;
               left_n  = SNOOZE_INIT;
               beep_n  = 1'b0;
            end else if (bus.snooze_key && (left_q != 3'd0)) begin
               state_n = SNOOZE;
               count_n = '0;
               left_n  = left_q - 3'd1;
               beep_n  = 1'b0;
            end else if (bus.sec_tick) begin
               if (count_q == RING_LAST) begin
                  state_n = ARMED;
                  count_n = '0;
                  left_n  = SNOOZE_INIT;
                  beep_n  = 1'b0;
               end else begin
                  count_n = count_q + 9'd1;
                  beep_n  = !beep_q;
               end
            end
         end
         SNOOZE: begin
            if (bus.stop_key) begin
               state_n = ARMED;
               count_n = '0;
               left_n  = SNOOZE_INIT;
               beep_n  = 1'b0;
            end else if (bus.sec_tick) begin
               if (count_q == SNOOZE_LAST) begin
                  state_n = RINGING;
                  count_n = '0;
                  beep_n  = 1'b1;
               end else begin
                  count_n = count_q + 9'd1;
               end
            end
         end
         default: begin
            state_n = DISARMED;
         end
      endcase

      // Disarming overrides every key and tick seen in the same cycle.
      if (!bus.alarm_en) begin
         state_n = DISARMED;
         count_n = '0;
         left_n  = SNOOZE_INIT;
         beep_n  = 1'b0;
      end

      ringing_n = (state_n == RINGING);
   end

   assign bus.state       = state_q;
   assign bus.ringing     = ringing_q;
   assign bus.beep        = beep_q;
   assign bus.snooze_left = left_q;

endmodule
